// File: rtl/fr_round_pack.sv
// Round-to-nearest-even and IEEE-754 single pack stage of the FP MAC datapath.
// Two-stage valid/ready pipeline: stage 1 rounds, stage 2 fixes exponent and packs.
module fr_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAN_W+1:0]   in_sig,
    input  logic [EXP_W-1:0]   in_exp,
    input  logic               in_sign,
    input  logic               in_sticky,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W+MAN_W:0] out_word,
    output logic               out_inexact,
    output logic               out_overflow,
    output logic               out_underflow
);

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

    logic s1_v_q;
    logic s2_v_q;
    logic s2_load;

    assign s2_load  = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || s2_load;

    // Stage 1: field select and round
    logic [MAN_W-1:0] frac;
    logic             g_bit;
    logic             rnd;
    logic [MAN_W:0]   sum_d;

    always_comb begin
        frac  = in_sig[MAN_W+1] ? in_sig[MAN_W:1] : in_sig[MAN_W-1:0];
        g_bit = in_sig[MAN_W+1] & in_sig[0];
        rnd   = g_bit & (frac[0] | in_sticky);
        sum_d = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    end

    logic [MAN_W:0]   sum_q;
    logic [EXP_W-1:0] exp_q;
    logic             sign_q;
    logic             inx1_q;
    logic             zero_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_q <= 1'b0;
            sum_q  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
            inx1_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (in_ready) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                exp_q  <= in_exp;
                sign_q <= in_sign;
                inx1_q <= g_bit | in_sticky;
                zero_q <= (in_sig == '0);
            end
        end
    end

    // Stage 2: exponent adjust, saturate/flush, pack
    logic [EXP_W:0]       e_sum;
    logic                 ovf;
    logic [EXP_W+MAN_W:0] word_d;
    logic                 inx_d;
    logic                 ovf_d;
    logic                 unf_d;

    always_comb begin
        e_sum  = {1'b0, exp_q} + {{EXP_W{1'b0}}, sum_q[MAN_W]};
        ovf    = (e_sum >= {1'b0, EXP_MAX});
        word_d = {sign_q, e_sum[EXP_W-1:0],
                  sum_q[MAN_W] ? {MAN_W{1'b0}} : sum_q[MAN_W-1:0]};
        inx_d  = inx1_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (zero_q) begin
            word_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            inx_d  = 1'b0;
        end else if (exp_q == '0) begin
            word_d = {sign_q, {(EXP_W+MAN_W){1'b0}}};
            inx_d  = 1'b1;
            unf_d  = 1'b1;
        end else if (ovf) begin
            word_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            inx_d  = 1'b1;
            ovf_d  = 1'b1;
        end
    end

    logic [EXP_W+MAN_W:0] word_q;
    logic                 inx_q;
    logic                 ovf_q;
    logic                 unf_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            s2_v_q <= 1'b0;
            word_q <= '0;
            inx_q  <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (s2_load) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                word_q <= word_d;
                inx_q  <= inx_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
            end
        end
    end

    // Flags carry meaning only alongside a valid result
    assign out_valid     = s2_v_q;
    assign out_word      = word_q;
    assign out_inexact   = s2_v_q & inx_q;
    assign out_overflow  = s2_v_q & ovf_q;
    assign out_underflow = s2_v_q & unf_q;

endmodule

// File: tb/tb_fr_round_pack.sv
// Bench for fr_round_pack: directed vector table, stall/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_fr_round_pack;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_sig;
    logic [7:0]  in_exp;
    logic        in_sign;
    logic        in_sticky;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        out_inexact;
    logic        out_overflow;
    logic        out_underflow;

    fr_round_pack dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sig(in_sig), .in_exp(in_exp),
        .in_sign(in_sign), .in_sticky(in_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_inexact(out_inexact),
        .out_overflow(out_overflow), .out_underflow(out_underflow)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;
    bit sb_on  = 1'b0;
    logic [34:0] sbq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Value-level model: {word, inexact, overflow, underflow}
    function automatic logic [34:0] model(input logic [24:0] sig, input logic [7:0] ex,
                                          input logic sg, input logic st);
        int unsigned q, half, e;
        logic inx;
        if (sig == 0) return {sg, 31'b0, 3'b000};
        q    = sig[24] ? (sig >> 1) : sig;
        half = sig[24] ? (sig & 1) : 0;
        if (half != 0 && ((q & 1) != 0 || st)) q = q + 1;
        e = ex;
        if (q >= (1 << 24)) begin
            e = e + 1;
            q = q >> 1;
        end
        inx = (half != 0) || st;
        if (ex == 0) return {sg, 31'b0, 3'b101};
        if (e >= 255) return {sg, 8'hFF, 23'b0, 3'b110};
        return {sg, e[7:0], q[22:0], inx, 2'b00};
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            sbq.delete();
        end else if (sb_on) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", {31'b0, out_valid}, 64'd0);
                end else begin
                    chk("sb_word", {32'b0, out_word}, {32'b0, sbq[0][34:3]});
                    chk("sb_flags", {61'b0, out_inexact, out_overflow, out_underflow},
                        {61'b0, sbq[0][2:0]});
                    void'(sbq.pop_front());
                end
            end
            if (in_valid && in_ready)
                sbq.push_back(model(in_sig, in_exp, in_sign, in_sticky));
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [24:0] s, input logic [7:0] e,
                          input logic sg, input logic st);
        in_sig = s; in_exp = e; in_sign = sg; in_sticky = st;
    endtask

    task automatic rand_in;
        logic [24:0] s;
        logic [7:0]  e;
        int m;
        s = 25'($urandom);
        m = $urandom_range(0, 3);
        if (m == 0) s[24] = 1'b1;
        else if (m == 1) s = {2'b01, s[22:0]};
        else if (m == 2) s = {2'b01, s[22:1], 1'b1};
        if ($urandom_range(0, 15) == 0) s = 25'd0;
        e = 8'($urandom);
        m = $urandom_range(0, 9);
        if (m == 0) e = 8'd0;
        else if (m == 1) e = 8'd254;
        else if (m == 2) e = 8'd255;
        set_in(s, e, 1'($urandom), 1'($urandom));
    endtask

    task automatic drain;
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sbq.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        tick();
        chk("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    typedef struct {
        logic [24:0] sig;
        logic [7:0]  ex;
        logic        sg;
        logic        st;
        logic [31:0] word;
        logic [2:0]  flags;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [31:0] held;
        int sent;
        int cyc;

        vt.push_back('{25'h0C00000, 8'd127, 1'b0, 1'b0, 32'h3FC00000, 3'b000});
        vt.push_back('{25'h1000001, 8'd127, 1'b0, 1'b0, 32'h3F800000, 3'b100});
        vt.push_back('{25'h1000003, 8'd127, 1'b0, 1'b0, 32'h3F800002, 3'b100});
        vt.push_back('{25'h1FFFFFF, 8'd127, 1'b0, 1'b0, 32'h40000000, 3'b100});
        vt.push_back('{25'h1FFFFFF, 8'd254, 1'b0, 1'b0, 32'h7F800000, 3'b110});
        vt.push_back('{25'h0800000, 8'd0,   1'b1, 1'b0, 32'h80000000, 3'b101});
        vt.push_back('{25'h0000000, 8'd90,  1'b1, 1'b0, 32'h80000000, 3'b000});
        vt.push_back('{25'h0800000, 8'd255, 1'b0, 1'b0, 32'h7F800000, 3'b110});
        vt.push_back('{25'h0800000, 8'd254, 1'b0, 1'b0, 32'h7F000000, 3'b000});
        vt.push_back('{25'h0800001, 8'd100, 1'b0, 1'b1, 32'h32000001, 3'b100});
        vt.push_back('{25'h1000002, 8'd127, 1'b0, 1'b1, 32'h3F800001, 3'b100});
        vt.push_back('{25'h1000005, 8'd127, 1'b0, 1'b0, 32'h3F800002, 3'b100});
        vt.push_back('{25'h1000005, 8'd127, 1'b1, 1'b1, 32'hBF800003, 3'b100});

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_in('0, '0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_out_word", {32'b0, out_word}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        tick();

        // Directed table, one beat at a time, checking 2-cycle latency
        out_ready = 1'b1;
        foreach (vt[i]) begin
            set_in(vt[i].sig, vt[i].ex, vt[i].sg, vt[i].st);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            @(negedge clock);
            chk("lat_early", {63'b0, out_valid}, 64'd0);
            tick();
            @(negedge clock);
            chk("vec_valid", {63'b0, out_valid}, 64'd1);
            chk("vec_word", {32'b0, out_word}, {32'b0, vt[i].word});
            chk("vec_flags", {61'b0, out_inexact, out_overflow, out_underflow},
                {61'b0, vt[i].flags});
            tick();
        end

        // Backpressure: 4 beats, consumer stalled for the first 3 cycles
        sb_on = 1'b1;
        sent = 0;
        held = '0;
        cyc = 0;
        while (sent < 4 && cyc < 20) begin
            out_ready = (cyc >= 3);
            in_valid  = 1'b1;
            rand_in();
            @(negedge clock);
            if (cyc == 2) begin
                chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
                held = out_word;
            end
            if (cyc == 3) chk("stall_hold", {32'b0, out_word}, {32'b0, held});
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        chk("stall_sent", 64'(sent), 64'd4);
        drain();

        // Reset with both stages full: dropped beats must never appear
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_in();
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("mid_rst_word", {32'b0, out_word}, 64'd0);
        chk("mid_rst_flags", {61'b0, out_inexact, out_overflow, out_underflow}, 64'd0);
        chk("mid_rst_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        repeat (5) tick();

        // Randomized traffic with random gaps and backpressure
        sent = 0;
        cyc = 0;
        while (sent < 300 && cyc < 3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_in();
            @(negedge clock);
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        chk("rand_sent", 64'(sent), 64'd300);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
